// File: rtl/chords_pkg.sv
// Shared defaults, state encodings and mixer scaling for the chord voice scheduler.
package chords_pkg;

    localparam int DEFAULT_NUM_VOICES = 3;
    localparam int DEFAULT_NOTE_W     = 6;
    localparam int DEFAULT_DUR_W      = 6;
    localparam int DEFAULT_SAMPLE_W   = 16;
    localparam int DEFAULT_TIMEOUT    = 255;

    // Mixed sum carries two guard bits; shifting them back out keeps the result in range.
    localparam int MIX_SHIFT = 2;

    typedef enum logic {
        V_IDLE,
        V_BUSY
    } voice_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_COLLECT,
        M_SUM,
        M_OUT
    } mix_state_t;

endpackage

// File: rtl/chord_mixer.sv
// Gathers one sample per voice per period, sums the busy contributors and emits a scaled mix.
module chord_mixer
    import chords_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_VOICES-1:0]          voice_busy,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_sample_ready,
    output logic [SAMPLE_W-1:0]            sample_out,
    output logic                           new_sample_ready
);

    localparam int SUM_W = SAMPLE_W + MIX_SHIFT;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mix_state_t                 state;
    mix_state_t                 next_state;
    logic [NUM_VOICES-1:0]      mask;
    logic [NUM_VOICES-1:0]      mask_next;
    logic [CNT_W-1:0]           count;
    logic signed [SAMPLE_W-1:0] latched [NUM_VOICES];
    logic signed [SUM_W-1:0]    sum;
    logic signed [SUM_W-1:0]    scaled;

    // A complete mask jumps straight to M_SUM so the last pulse always lands two cycles before
    // the output; expiry fires at TIMEOUT-2 so the pulse appears TIMEOUT cycles after the first ready.
    always_comb begin
        next_state = state;
        mask_next  = mask;
        if (state == M_IDLE || state == M_COLLECT) begin
            mask_next = mask | voice_sample_ready;
        end
        case (state)
            M_IDLE: begin
                if (|voice_sample_ready) begin
                    next_state = (&mask_next) ? M_SUM : M_COLLECT;
                end
            end
            M_COLLECT: begin
                if ((&mask_next) || (count >= CNT_W'(TIMEOUT - 2))) begin
                    next_state = M_SUM;
                end
            end
            M_SUM:   next_state = M_OUT;
            M_OUT:   next_state = M_IDLE;
            default: next_state = M_IDLE;
        endcase
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_busy[i] && mask[i]) begin
                sum = sum + SUM_W'(latched[i]);
            end
        end
        scaled = sum >>> MIX_SHIFT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= M_IDLE;
            mask       <= '0;
            count      <= '0;
            sample_out <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                latched[i] <= '0;
            end
        end else begin
            state <= next_state;
            mask  <= (state == M_OUT) ? '0 : mask_next;
            if (state == M_IDLE || state == M_COLLECT) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (voice_sample_ready[i]) begin
                        latched[i] <= voice_sample[i*SAMPLE_W +: SAMPLE_W];
                    end
                end
            end
            if (state == M_IDLE) begin
                count <= CNT_W'(1);
            end else if (state == M_COLLECT) begin
                count <= count + CNT_W'(1);
            end
            if (state == M_SUM) begin
                sample_out <= scaled[SAMPLE_W-1:0];
            end
        end
    end

    assign new_sample_ready = (state == M_OUT);

endmodule

// File: rtl/chord_voice_scheduler.sv
// Allocates note requests round-robin across idle voices and forwards the mixed voice output.
module chord_voice_scheduler
    import chords_pkg::*;
#(
    parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int NOTE_W     = DEFAULT_NOTE_W,
    parameter int DUR_W      = DEFAULT_DUR_W,
    parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic [NOTE_W-1:0]              note,
    input  logic [DUR_W-1:0]               duration,
    input  logic                           new_note,
    output logic                           player_ready,
    output logic [NUM_VOICES-1:0]          load_note,
    output logic [NOTE_W-1:0]              note_out,
    output logic [DUR_W-1:0]               duration_out,
    input  logic [NUM_VOICES-1:0]          voice_done,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    input  logic [NUM_VOICES-1:0]          voice_sample_ready,
    output logic [SAMPLE_W-1:0]            sample_out,
    output logic                           new_sample_ready
);

    localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    voice_state_t          voice_state [NUM_VOICES];
    logic [NUM_VOICES-1:0] busy;
    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      sel_idx;
    logic                  found;
    logic                  accept;
    int                    cand;

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            busy[i] = (voice_state[i] == V_BUSY);
        end
    end

    assign player_ready = play & ~reset & ~(&busy);
    assign accept       = new_note & player_ready;

    // Only the registered busy bits decide eligibility, so a voice finishing this cycle waits one more.
    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_VOICES) begin
                cand = cand - NUM_VOICES;
            end
            if (!found && !busy[cand]) begin
                found   = 1'b1;
                sel_idx = PTR_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_state[i] <= V_IDLE;
            end
            rr_ptr       <= '0;
            load_note    <= '0;
            note_out     <= '0;
            duration_out <= '0;
        end else begin
            load_note <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (voice_done[i]) begin
                    voice_state[i] <= V_IDLE;
                end
            end
            if (accept && found) begin
                voice_state[sel_idx] <= V_BUSY;
                load_note            <= NUM_VOICES'(1) << sel_idx;
                note_out             <= note;
                duration_out         <= duration;
                rr_ptr               <= (sel_idx == PTR_W'(NUM_VOICES - 1)) ? '0 : sel_idx + PTR_W'(1);
            end
        end
    end

    chord_mixer #(
        .NUM_VOICES (NUM_VOICES),
        .SAMPLE_W   (SAMPLE_W),
        .TIMEOUT    (TIMEOUT)
    ) u_mixer (
        .clk                (clk),
        .reset              (reset),
        .voice_busy         (busy),
        .voice_sample       (voice_sample),
        .voice_sample_ready (voice_sample_ready),
        .sample_out         (sample_out),
        .new_sample_ready   (new_sample_ready)
    );

endmodule

// File: tb/tb_chord_voice_scheduler.sv
// Directed scoreboard bench: stimulus queues expected loads/samples, a negedge monitor checks them.
module tb_chord_voice_scheduler;

    localparam int NV = 3;
    localparam int NW = 6;
    localparam int DW = 6;
    localparam int SW = 16;

    typedef struct {
        int mask;
        int note;
        int dur;
        int cyc;
    } load_exp_t;

    typedef struct {
        int value;
        int cyc;
    } samp_exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             play;
    logic [NW-1:0]    note;
    logic [DW-1:0]    duration;
    logic             new_note;
    logic             player_ready;
    logic [NV-1:0]    load_note;
    logic [NW-1:0]    note_out;
    logic [DW-1:0]    duration_out;
    logic [NV-1:0]    voice_done;
    logic [NV*SW-1:0] voice_sample;
    logic [NV-1:0]    voice_sample_ready;
    logic [SW-1:0]    sample_out;
    logic             new_sample_ready;

    int        cyc = 0;
    int        compared_cnt = 0;
    int        mismatched_cnt = 0;
    load_exp_t load_q [$];
    samp_exp_t samp_q [$];

    chord_voice_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .play               (play),
        .note               (note),
        .duration           (duration),
        .new_note           (new_note),
        .player_ready       (player_ready),
        .load_note          (load_note),
        .note_out           (note_out),
        .duration_out       (duration_out),
        .voice_done         (voice_done),
        .voice_sample       (voice_sample),
        .voice_sample_ready (voice_sample_ready),
        .sample_out         (sample_out),
        .new_sample_ready   (new_sample_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        compared_cnt++;
        if (actual != expected) begin
            mismatched_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp_mask of zero means the request is expected to be dropped.
    task automatic apply_stimulus(input int n, input int d, input int exp_mask);
        load_exp_t e;
        note     = NW'(n);
        duration = DW'(d);
        new_note = 1'b1;
        if (exp_mask != 0) begin
            e.mask = exp_mask;
            e.note = n;
            e.dur  = d;
            e.cyc  = cyc + 1;
            load_q.push_back(e);
        end
        tick();
        new_note = 1'b0;
    endtask

    task automatic set_sample(input int v, input int val);
        voice_sample[v*SW +: SW] = SW'(val);
    endtask

    task automatic pulse_ready(input logic [NV-1:0] mask, input int exp_val, input int exp_delay);
        samp_exp_t e;
        voice_sample_ready = mask;
        if (exp_delay > 0) begin
            e.value = exp_val;
            e.cyc   = cyc + exp_delay;
            samp_q.push_back(e);
        end
        tick();
        voice_sample_ready = '0;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (load_q.size() != 0 || samp_q.size() != 0); i++) begin
            tick();
        end
        check_output("load_queue_drained", load_q.size(), 0);
        check_output("sample_queue_drained", samp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (load_note != '0) begin
                if (load_q.size() == 0) begin
                    check_output("unexpected_load", int'(load_note), 0);
                end else begin
                    load_exp_t e;
                    e = load_q.pop_front();
                    check_output("load_mask", int'(load_note), e.mask);
                    check_output("load_note_out", int'(note_out), e.note);
                    check_output("load_duration_out", int'(duration_out), e.dur);
                    check_output("load_cycle", cyc, e.cyc);
                end
            end
            if (new_sample_ready) begin
                if (samp_q.size() == 0) begin
                    check_output("unexpected_sample", int'($signed(sample_out)), 0);
                end else begin
                    samp_exp_t e;
                    e = samp_q.pop_front();
                    check_output("sample_value", int'($signed(sample_out)), e.value);
                    check_output("sample_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        play               = 1'b1;
        note               = '0;
        duration           = '0;
        new_note           = 1'b0;
        voice_done         = '0;
        voice_sample       = '0;
        voice_sample_ready = '0;

        #3;
        check_output("ready_in_reset", int'(player_ready), 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_output("ready_after_reset", int'(player_ready), 1);
        check_output("load_after_reset", int'(load_note), 0);
        check_output("sample_after_reset", int'(sample_out), 0);
        check_output("nsr_after_reset", int'(new_sample_ready), 0);
        tick();

        $display("[TB] round-robin fill");
        apply_stimulus(10, 4, 3'b001);
        apply_stimulus(20, 4, 3'b010);
        apply_stimulus(30, 4, 3'b100);
        check_output("ready_all_busy", int'(player_ready), 0);
        apply_stimulus(50, 5, 0);
        tick();
        check_output("note_kept_after_drop", int'(note_out), 30);
        check_output("dur_kept_after_drop", int'(duration_out), 4);

        $display("[TB] release and reuse");
        voice_done = 3'b010;
        note       = 6'd40;
        duration   = 6'd7;
        new_note   = 1'b1;
        tick();
        voice_done = '0;
        new_note   = 1'b0;
        check_output("ready_after_done", int'(player_ready), 1);
        apply_stimulus(40, 7, 3'b010);
        tick();
        check_output("ready_refilled", int'(player_ready), 0);
        check_output("note_held", int'(note_out), 40);

        $display("[TB] mix arithmetic");
        set_sample(0, 4000);
        pulse_ready(3'b001, 0, 0);
        set_sample(1, -1000);
        pulse_ready(3'b010, 0, 0);
        set_sample(2, 800);
        pulse_ready(3'b100, 950, 2);
        drain(10);
        set_sample(0, 32767);
        set_sample(1, 32767);
        set_sample(2, 32767);
        pulse_ready(3'b111, 24575, 2);
        drain(10);
        check_output("sample_held", int'($signed(sample_out)), 24575);

        $display("[TB] idle masking");
        voice_done = 3'b100;
        tick();
        voice_done = '0;
        set_sample(0, 400);
        set_sample(1, 400);
        set_sample(2, 1000);
        pulse_ready(3'b111, 200, 2);
        drain(10);
        set_sample(0, -1000);
        set_sample(1, -3);
        set_sample(2, 5000);
        pulse_ready(3'b111, -251, 2);
        drain(10);

        $display("[TB] timeout");
        apply_stimulus(33, 9, 3'b100);
        tick();
        set_sample(0, 1000);
        set_sample(1, 9999);
        set_sample(2, 2000);
        pulse_ready(3'b001, 750, 255);
        tick();
        pulse_ready(3'b100, 0, 0);
        drain(300);

        $display("[TB] reset mid-operation");
        voice_done = 3'b001;
        tick();
        voice_done = '0;
        set_sample(1, 123);
        pulse_ready(3'b010, 0, 0);
        apply_stimulus(12, 3, 0);
        #1;
        reset = 1'b1;
        #1;
        check_output("rst_load_note", int'(load_note), 0);
        check_output("rst_note_out", int'(note_out), 0);
        check_output("rst_duration_out", int'(duration_out), 0);
        check_output("rst_sample_out", int'(sample_out), 0);
        check_output("rst_nsr", int'(new_sample_ready), 0);
        check_output("rst_player_ready", int'(player_ready), 0);
        tick();
        reset = 1'b0;
        #1;
        check_output("ready_post_reset", int'(player_ready), 1);
        apply_stimulus(15, 2, 3'b001);
        tick();
        set_sample(0, 100);
        set_sample(1, 200);
        set_sample(2, 300);
        pulse_ready(3'b111, 25, 2);
        drain(20);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatched_cnt);
        $finish;
    end

endmodule

// File: doc/chord_voice_scheduler.md
Name: chord_voice_scheduler

Overview:
- Sits between the song reader and a bank of NUM_VOICES note_player instances so that chords play polyphonically.
- Accepts one note request at a time and allocates it to a free voice using round-robin order.
- Tracks each voice as busy or idle from its done pulse.
- Collects one sample per voice per sample period, mixes them into a single sample, and hands that sample to the codec path with a ready pulse.

Parameters:
- NUM_VOICES, 3, number of note_player voices managed.
- NOTE_W, 6, note code width.
- DUR_W, 6, duration width in beats.
- SAMPLE_W, 16, signed sample width.
- TIMEOUT, 255, maximum cycles the mixer waits for all voice samples before emitting.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- play  in  1  play enable; when low, requests are refused.
- note  in  NOTE_W  requested note.
- duration  in  DUR_W  requested duration.
- new_note  in  1  single-cycle request strobe.
- player_ready  out  1  high when at least one voice is idle and play=1.
- load_note  out  NUM_VOICES  one-hot, single-cycle load strobe to the voices.
- note_out  out  NOTE_W  registered note broadcast to all voices.
- duration_out  out  DUR_W  registered duration broadcast to all voices.
- voice_done  in  NUM_VOICES  per-voice done_with_note pulse.
- voice_sample  in  NUM_VOICES*SAMPLE_W  packed voice samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W].
- voice_sample_ready  in  NUM_VOICES  per-voice new_sample_ready pulse.
- sample_out  out  SAMPLE_W  mixed signed sample.
- new_sample_ready  out  1  single-cycle pulse marking a valid sample_out.

Behaviour:
- Reset (asynchronous, any time, including mid-collection or mid-load):
  - All voices IDLE; round-robin pointer = 0; ready mask cleared; mixer FSM in M_IDLE.
  - load_note=0, note_out=0, duration_out=0, sample_out=0, new_sample_ready=0.
  - player_ready=0 during reset; it evaluates normally from the first cycle after reset.
- Voice state: one IDLE/BUSY bit per voice, registered.
  - IDLE->BUSY on the cycle its load_note is asserted.
  - BUSY->IDLE on the clock edge sampling voice_done[i]=1.
- player_ready is combinational: play & (any voice IDLE).
- Accept condition: new_note=1 and player_ready=1 in cycle N.
  - Cycle N+1: exactly one load_note bit high; note_out/duration_out hold the values captured at N.
  - Chosen voice: first IDLE voice searching from the pointer upward, wrapping modulo NUM_VOICES. The pointer then advances to chosen+1, wrapping to 0.
  - new_note while player_ready=0 is dropped; no state change occurs.
- Simultaneous events:
  - voice_done[i] in the same cycle as an accepted new_note: voice i is not eligible at that edge. It becomes eligible from the next cycle.
  - Back-to-back new_note at N and N+1 selects two distinct voices, because the BUSY bit is set at the N+1 edge before the second search.
- note_out/duration_out retain their values between loads.
- Mixer FSM:
  - States: M_IDLE, M_COLLECT, M_SUM, M_OUT.
  - M_IDLE -> M_COLLECT on any voice_sample_ready bit.
  - M_COLLECT:
    - On each voice_sample_ready[i], latch voice i's sample and set mask[i].
    - Count wait cycles from the first ready pulse.
    - Go to M_SUM when the mask is all ones or the count reaches TIMEOUT.
    - A repeat pulse from a voice whose mask bit is already set overwrites that voice's latched sample.
  - M_SUM: sum the sign-extended latched samples into SAMPLE_W+2 bits. A voice contributes 0 if it is IDLE or its mask bit is clear. Arithmetic shift right by 2 gives the result, which cannot overflow.
  - M_OUT: drive sample_out and pulse new_sample_ready for 1 cycle; clear the mask; return to M_IDLE.
  - Latency: the final ready pulse at cycle N gives new_sample_ready at N+2.
  - sample_out holds its value until the next M_OUT.
- play=0 blocks new loads only. Already-BUSY voices keep sounding until their done pulse, and the mixer keeps running.

Decomposition:
- chords_pkg holds:
  - NUM_VOICES/NOTE_W/DUR_W/SAMPLE_W defaults;
  - the voice_state_t enum {V_IDLE, V_BUSY};
  - the mix_state_t enum {M_IDLE, M_COLLECT, M_SUM, M_OUT};
  - the MIX_SHIFT=2 constant.
- One sub-module, chord_mixer: the mixer FSM, sample latches, mask and timeout counter. It receives the busy vector from the allocator logic in the top level.

Test Plan:
- Reset then idle: after reset, play=1 -> player_ready=1, load_note=000, sample_out=0, new_sample_ready=0.
- Round-robin fill: notes 10, 20, 30 with durations 4, 4, 4 on consecutive cycles -> load_note = 001, 010, 100 one cycle after each request; note_out = 10, 20, 30; player_ready falls to 0 after the third load. A 4th new_note is dropped with no load_note pulse.
- Release/reuse: with all voices busy, pulse voice_done=010 together with new_note (note 40) -> the request is dropped. new_note the next cycle -> load_note=010, note_out=40.
- Mix arithmetic: all voices busy; samples 16'sd4000, -16'sd1000, 16'sd800 with ready pulses at cycles 0, 1, 2 -> new_sample_ready at cycle 4, sample_out=950. Then all three samples at 16'sh7FFF -> sample_out=24575, no wrap.
- Idle masking and timeout: voice 2 idle with sample 1000 and busy voices at 400 each, all ready -> sample_out=200. With voice 1's ready withheld and TIMEOUT=255 (2nd case) -> emission 255 cycles after the first pulse, using zero for voice 1.
- Reset mid-operation: assert reset during M_COLLECT with 2 voices busy -> outputs return to 0 asynchronously, all voices idle, and the next request loads voice 0.
